// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch PC with fixed-priority next-PC selection.
// Defining PC_GEN_BTB_EN adds a direct-mapped BTB with 2-bit counters, trained from EX.
module pc_gen #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned      BTB_DEPTH    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             exc_req_i,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_target_i,
  input  logic             upd_valid_i,
  input  logic [WIDTH-1:0] upd_pc_i,
  input  logic [WIDTH-1:0] upd_target_i,
  input  logic             upd_taken_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc4_o,
  output logic             pred_taken_o,
  output logic [WIDTH-1:0] pred_target_o
);

  localparam int unsigned IDX  = $clog2(BTB_DEPTH);
  localparam int unsigned TAGW = WIDTH - IDX - 2;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc4_s;
  logic             pred_taken_s;
  logic [WIDTH-1:0] pred_target_s;

  assign pc4_s = pc_q + WIDTH'(32'd4);

`ifdef PC_GEN_BTB_EN
  logic [BTB_DEPTH-1:0] btb_valid_q;
  logic [TAGW-1:0]      btb_tag_q [BTB_DEPTH];
  logic [WIDTH-1:0]     btb_tgt_q [BTB_DEPTH];
  logic [1:0]           btb_ctr_q [BTB_DEPTH];

  logic [IDX-1:0]  lk_idx_s;
  logic [IDX-1:0]  up_idx_s;
  logic [TAGW-1:0] lk_tag_s;
  logic [TAGW-1:0] up_tag_s;
  logic            lk_hit_s;
  logic            up_hit_s;
  logic            unused_upd_s;

  assign lk_idx_s = pc_q[IDX+1:2];
  assign lk_tag_s = pc_q[WIDTH-1:IDX+2];
  assign up_idx_s = upd_pc_i[IDX+1:2];
  assign up_tag_s = upd_pc_i[WIDTH-1:IDX+2];
  assign unused_upd_s = ^upd_pc_i[1:0];

  // Lookup reads pre-update contents; a same-index write only becomes visible after the edge.
  assign lk_hit_s      = btb_valid_q[lk_idx_s] && (btb_tag_q[lk_idx_s] == lk_tag_s);
  assign up_hit_s      = btb_valid_q[up_idx_s] && (btb_tag_q[up_idx_s] == up_tag_s);
  assign pred_taken_s  = lk_hit_s && btb_ctr_q[lk_idx_s][1];
  assign pred_target_s = pred_taken_s ? btb_tgt_q[lk_idx_s] : pc4_s;

  // BTB training from EX; independent of stall, redirect and exception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid_q <= '0;
      btb_tag_q   <= '{default: '0};
      btb_tgt_q   <= '{default: '0};
      btb_ctr_q   <= '{default: 2'b01};
    end else if (upd_valid_i) begin
      if (up_hit_s) begin
        if (upd_taken_i) begin
          if (btb_ctr_q[up_idx_s] != 2'b11) begin
            btb_ctr_q[up_idx_s] <= btb_ctr_q[up_idx_s] + 2'b01;
          end
          btb_tgt_q[up_idx_s] <= upd_target_i;
        end else if (btb_ctr_q[up_idx_s] != 2'b00) begin
          btb_ctr_q[up_idx_s] <= btb_ctr_q[up_idx_s] - 2'b01;
        end
      end else if (upd_taken_i) begin
        btb_valid_q[up_idx_s] <= 1'b1;
        btb_tag_q[up_idx_s]   <= up_tag_s;
        btb_tgt_q[up_idx_s]   <= upd_target_i;
        btb_ctr_q[up_idx_s]   <= 2'b10;
      end
    end
  end
`else
  logic unused_upd_s;

  assign unused_upd_s  = ^{upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i};
  assign pred_taken_s  = 1'b0;
  assign pred_target_s = pc4_s;
`endif

  // Next-PC selection; exception and redirect flush the pipe, so they beat stall.
  always_comb begin
    pc_d = pc4_s;
    if (exc_req_i) begin
      pc_d = EXC_VECTOR;
    end else if (redirect_valid_i) begin
      pc_d = redirect_target_i;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (pred_taken_s) begin
      pc_d = pred_target_s;
    end else begin
      pc_d = pc4_s;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc4_o         = pc4_s;
  assign pred_taken_o  = pred_taken_s;
  assign pred_target_o = pred_target_s;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential fetch, priority, wrap, async reset and,
// when PC_GEN_BTB_EN is defined, BTB allocate/hysteresis/aliasing/no-bypass.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        exc_req_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic        upd_taken_i;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;

  int checks   = 0;
  int failures = 0;

  pc_gen dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .exc_req_i         (exc_req_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_target_i      (upd_target_i),
    .upd_taken_i       (upd_taken_i),
    .pc_o              (pc_o),
    .pc4_o             (pc4_o),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] tgt);
    redirect_valid_i  = 1'b1;
    redirect_target_i = tgt;
    step();
    redirect_valid_i  = 1'b0;
  endtask

  task automatic upd(input logic [31:0] upc, input logic [31:0] tgt, input logic tk);
    upd_valid_i  = 1'b1;
    upd_pc_i     = upc;
    upd_target_i = tgt;
    upd_taken_i  = tk;
    step();
    upd_valid_i  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    exc_req_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_target_i = 32'h0;
    upd_valid_i = 1'b0;
    upd_pc_i = 32'h0;
    upd_target_i = 32'h0;
    upd_taken_i = 1'b0;

    #2;
    chk("reset_pc", pc_o, 32'h0000_0000);
    chk("reset_pc4", pc4_o, 32'h0000_0004);
    chk("reset_pred", {31'd0, pred_taken_o}, 32'h0);
    #10;
    chk("reset_held_over_edge", pc_o, 32'h0000_0000);
    rst = 1'b0;

    // Sequential fetch
    step(); chk("seq_4", pc_o, 32'h0000_0004);
    step(); chk("seq_8", pc_o, 32'h0000_0008);
    step(); chk("seq_c", pc_o, 32'h0000_000C);
    step(); chk("seq_10", pc_o, 32'h0000_0010);
    chk("seq_pred", {31'd0, pred_taken_o}, 32'h0);

    // Priority
    redir(32'h0000_0020);
    chk("redir_20", pc_o, 32'h0000_0020);
    stall_i = 1'b1; exc_req_i = 1'b1;
    redir(32'h0000_0100);
    exc_req_i = 1'b0;
    chk("prio_exc", pc_o, 32'h8000_0180);
    stall_i = 1'b0;
    redir(32'h0000_0020);
    stall_i = 1'b1;
    redir(32'h0000_0100);
    chk("prio_redirect_over_stall", pc_o, 32'h0000_0100);
    stall_i = 1'b0;
    redir(32'h0000_0020);
    stall_i = 1'b1;
    step(); chk("stall_hold_1", pc_o, 32'h0000_0020);
    step(); chk("stall_hold_2", pc_o, 32'h0000_0020);
    step(); chk("stall_hold_3", pc_o, 32'h0000_0020);
    stall_i = 1'b0;
    step(); chk("stall_release", pc_o, 32'h0000_0024);
    chk("no_pred_target_is_pc4", pred_target_o, 32'h0000_0028);

    // Wrap
    redir(32'hFFFF_FFFC);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_o, 32'h0000_0000);
    step(); chk("wrap_next", pc_o, 32'h0000_0000);

`ifdef PC_GEN_BTB_EN
    // Allocate and predict
    upd(32'h0000_0040, 32'h0000_0200, 1'b1);
    redir(32'h0000_0040);
    chk("alloc_pred", {31'd0, pred_taken_o}, 32'h1);
    chk("alloc_target", pred_target_o, 32'h0000_0200);
    step(); chk("follow_pred", pc_o, 32'h0000_0200);
    upd(32'h0000_0080, 32'h0000_0500, 1'b0);
    redir(32'h0000_0080);
    chk("miss_nt_no_alloc", {31'd0, pred_taken_o}, 32'h0);

    // Hysteresis: park pc at 0x40 and train under stall
    redir(32'h0000_0040);
    stall_i = 1'b1;
    chk("hyst_ctr10", {31'd0, pred_taken_o}, 32'h1);
    upd(32'h0000_0040, 32'h0000_0200, 1'b0);
    chk("hyst_ctr01", {31'd0, pred_taken_o}, 32'h0);
    upd(32'h0000_0040, 32'h0000_0200, 1'b1);
    upd(32'h0000_0040, 32'h0000_0200, 1'b1);
    upd(32'h0000_0040, 32'h0000_0200, 1'b0);
    chk("hyst_ctr11_to_10", {31'd0, pred_taken_o}, 32'h1);
    chk("hyst_target", pred_target_o, 32'h0000_0200);
    upd(32'h0000_0040, 32'h0000_0200, 1'b0);
    upd(32'h0000_0040, 32'h0000_0200, 1'b0);
    upd(32'h0000_0040, 32'h0000_0200, 1'b0);
    chk("hyst_sat_00", {31'd0, pred_taken_o}, 32'h0);
    upd(32'h0000_0040, 32'h0000_0210, 1'b1);
    chk("hyst_00_to_01", {31'd0, pred_taken_o}, 32'h0);
    upd(32'h0000_0040, 32'h0000_0210, 1'b1);
    chk("hyst_01_to_10", {31'd0, pred_taken_o}, 32'h1);
    chk("hit_taken_retarget", pred_target_o, 32'h0000_0210);

    // Aliasing: 0x440 shares index 0 with 0x40
    upd(32'h0000_0440, 32'h0000_0300, 1'b1);
    chk("alias_evict", {31'd0, pred_taken_o}, 32'h0);
    chk("alias_target_pc4", pred_target_o, 32'h0000_0044);
    redir(32'h0000_0440);
    chk("alias_new_pred", {31'd0, pred_taken_o}, 32'h1);
    chk("alias_new_target", pred_target_o, 32'h0000_0300);

    // Same-cycle lookup/update: old value now, new value after the edge
    upd_valid_i = 1'b1; upd_pc_i = 32'h0000_0440; upd_target_i = 32'h0000_0300; upd_taken_i = 1'b0;
    #1;
    chk("nobypass_old", {31'd0, pred_taken_o}, 32'h1);
    step();
    upd_valid_i = 1'b0;
    chk("nobypass_new", {31'd0, pred_taken_o}, 32'h0);
    chk("nobypass_new_target", pred_target_o, 32'h0000_0444);

    // Async reset invalidates entries
    upd(32'h0000_0440, 32'h0000_0300, 1'b1);
    chk("pre_reset_pred", {31'd0, pred_taken_o}, 32'h1);
    #2; rst = 1'b1;
    #1;
    chk("async_rst_pc", pc_o, 32'h0000_0000);
    chk("async_rst_pred", {31'd0, pred_taken_o}, 32'h0);
    rst = 1'b0;
    redir(32'h0000_0440);
    chk("post_rst_pc", pc_o, 32'h0000_0440);
    chk("post_rst_invalid", {31'd0, pred_taken_o}, 32'h0);
    stall_i = 1'b0;
`else
    // Without the BTB, training is ignored
    upd(32'h0000_0040, 32'h0000_0200, 1'b1);
    redir(32'h0000_0040);
    chk("nobtb_pred", {31'd0, pred_taken_o}, 32'h0);
    chk("nobtb_target", pred_target_o, 32'h0000_0044);
    step(); chk("nobtb_next", pc_o, 32'h0000_0044);
`endif

    // Async reset between edges, no clock needed
    redir(32'h0000_1234);
    chk("pre_async_pc", pc_o, 32'h0000_1234);
    #2; rst = 1'b1;
    #1;
    chk("async_rst_pc_final", pc_o, 32'h0000_0000);
    chk("async_rst_pc4_final", pc4_o, 32'h0000_0004);
    rst = 1'b0;
    step(); chk("post_release_step", pc_o, 32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
